system_bus_controller: RTL and testbench
========================================

SYSTEM_BUS_CONTROLLER -- requirements
Module: system_bus_controller

Interface
REQ-001 Parameter ROM_WAIT, default 2: wait cycles for ROM accesses (0..15).
REQ-002 Parameter SRAM_WAIT, default 0: wait cycles for SRAM accesses (0..15).
REQ-003 Parameter DUART_WAIT, default 3: wait cycles for DUART accesses and DUART IACK cycles (0..15).
REQ-004 Parameter ROM_PORT / SRAM_PORT / DUART_PORT, defaults 8 / 32 / 8: port width in bits (8, 16 or 32), sets DSACK encoding.
REQ-005 Parameter EXP_PORT, default 16: expansion port width (8, 16 or 32).
REQ-006 Parameter BOOT_CYCLES, default 2: completed bus cycles served by the ROM overlay after reset (1..15).
REQ-007 Parameter TIMEOUT, default 64: cycles from cycle start to bus error (8..255).
REQ-008 Parameter DUART_IPL, default 5: DUART interrupt level (1..7).
REQ-009 CLK  in  1  system clock; sole clock; all state changes on rising edge.
REQ-010 RST  in  1  reset; synchronous, active-high.
REQ-011 AH  in  4  address bits 31:28.
REQ-012 AM  in  4  address bits 19:16.
REQ-013 AL  in  4  address bits 3:0.
REQ-014 FC  in  3  CPU function code.
REQ-015 AS_n  in  1  address strobe, active low.
REQ-016 EXP_RDY_n  in  1  expansion-device ready, active low.
REQ-017 IRQ_DUART_n  in  1  DUART interrupt request, active low.
REQ-018 DSACK0_n, DSACK1_n  out  1 each  data-transfer acknowledge.
REQ-019 BERR_n, AVEC_n, CIIN_n, STERM_n  out  1 each  bus error, autovector, cache inhibit, synchronous termination.
REQ-020 IPL_n  out  3  interrupt priority level, active low.
REQ-021 CS_ROM_n, CS_SRAM_n, CS_DUART_n, CS_EXP_n, IACK_DUART_n  out  1 each  selects, active low.

Function
REQ-022 All outputs SHALL be registered; STERM_n SHALL be constant 1.
REQ-023 States SHALL be IDLE, WAIT, ACK, TERM; IDLE samples AS_n each edge.
REQ-024 Decode at the edge AS_n is first sampled low (edge k): CPU space = FC==111; IACK = CPU space and AM==1111; otherwise memory region by AH[31:30]: 00 SRAM, 01 EXP, 10 ROM, 11 DUART.
REQ-025 While BOOT is active, every memory-space cycle SHALL select ROM regardless of AH.
REQ-026 At edge k: IDLE->WAIT, the selected CS_x_n (or IACK_DUART_n) SHALL go low, wait counter loaded with the region's WAIT parameter, timeout counter cleared.
REQ-027 Fixed-wait regions: WAIT->ACK when the counter is 0 and decrements otherwise; DSACK asserted from edge k+W+1, W the region wait.
REQ-028 EXP region: WAIT->ACK on the first edge EXP_RDY_n is sampled low; DSACK asserted at the following edge.
REQ-029 DSACK encoding: 8-bit port DSACK0_n=0/DSACK1_n=1; 16-bit DSACK0_n=1/DSACK1_n=0; 32-bit both 0.
REQ-030 CIIN_n SHALL be low with CS_DUART_n or CS_EXP_n, high otherwise.
REQ-031 IACK with AL[3:1]==DUART_IPL: IACK_DUART_n low, DSACK per DUART_PORT after DUART_WAIT.
REQ-032 IACK at any other level: AVEC_n low from edge k+1, state ACK.
REQ-033 CPU-space non-IACK cycles: BERR_n low from edge k+1, state TERM.
REQ-034 If the timeout counter reaches TIMEOUT in WAIT: WAIT->TERM, BERR_n low, chip select stays asserted.
REQ-035 ACK or TERM SHALL hold all asserted outputs until AS_n sampled high, then ->IDLE with all selects, DSACK, AVEC_n, BERR_n high at that edge.
REQ-036 AS_n sampled high while in WAIT (aborted cycle): ->IDLE, outputs deasserted, no boot count.
REQ-037 Boot counter: increments on each ACK->IDLE while BOOT; BOOT clears when count reaches BOOT_CYCLES; TERM exits and aborts do not count; saturates.
REQ-038 IPL_n SHALL be ~DUART_IPL (3 bits) one edge after IRQ_DUART_n sampled low, 111 one edge after sampled high.

Reset
REQ-039 RST sampled high SHALL, at that edge, force IDLE, BOOT active, boot count 0, counters 0, all outputs high (IPL_n=111), including mid-cycle.
REQ-040 Outputs SHALL remain at reset values while RST is high, regardless of AS_n.

Verification
REQ-041 Reset release, two fetches at 0x00000000 then one at 0x00000000 -> first two assert CS_ROM_n, DSACK0_n at k+3; third asserts CS_SRAM_n, DSACK0_n=DSACK1_n=0 at k+1.
REQ-042 After boot, read 0xC0000001 -> CS_DUART_n and CIIN_n low from k, DSACK0_n low at k+4, all high one edge after AS_n high.
REQ-043 Access 0x40000000, EXP_RDY_n never asserted -> BERR_n low at edge k+64, DSACK both high, CS_EXP_n low until AS_n high.
REQ-044 FC=111, AM=1111, AL[3:1]=5 -> IACK_DUART_n low, DSACK0_n at k+4; AL[3:1]=2 -> AVEC_n low at k+1.
REQ-045 RST asserted during ROM WAIT, released, read 0x00000000 -> CS_ROM_n selected (boot overlay restarted).
REQ-046 IRQ_DUART_n low -> IPL_n=010 one edge later; released -> 111 one edge later.

Source files
------------

// File: rtl/system_bus_controller.sv
// rtl/system_bus_controller.sv - 68k-style bus controller: address decode, wait states, DSACK, timeout, IACK, boot overlay
module system_bus_controller #(
    parameter int ROM_WAIT    = 2,
    parameter int SRAM_WAIT   = 0,
    parameter int DUART_WAIT  = 3,
    parameter int ROM_PORT    = 8,
    parameter int SRAM_PORT   = 32,
    parameter int DUART_PORT  = 8,
    parameter int EXP_PORT    = 16,
    parameter int BOOT_CYCLES = 2,
    parameter int TIMEOUT     = 64,
    parameter int DUART_IPL   = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] AH,
    input  logic [3:0] AM,
    input  logic [3:0] AL,
    input  logic [2:0] FC,
    input  logic       AS_n,
    input  logic       EXP_RDY_n,
    input  logic       IRQ_DUART_n,
    output logic       DSACK0_n,
    output logic       DSACK1_n,
    output logic       BERR_n,
    output logic       AVEC_n,
    output logic       CIIN_n,
    output logic       STERM_n,
    output logic [2:0] IPL_n,
    output logic       CS_ROM_n,
    output logic       CS_SRAM_n,
    output logic       CS_DUART_n,
    output logic       CS_EXP_n,
    output logic       IACK_DUART_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_TERM = 2'd3;

    // How a cycle in WAIT is finished
    localparam logic [1:0] K_FIXED = 2'd0;
    localparam logic [1:0] K_EXP   = 2'd1;
    localparam logic [1:0] K_AVEC  = 2'd2;
    localparam logic [1:0] K_BERR  = 2'd3;

    // DSACK pair encoded as {DSACK1_n, DSACK0_n}
    localparam logic [1:0] ENC_ROM   = (ROM_PORT == 8)   ? 2'b10 : (ROM_PORT == 16)   ? 2'b01 : 2'b00;
    localparam logic [1:0] ENC_SRAM  = (SRAM_PORT == 8)  ? 2'b10 : (SRAM_PORT == 16)  ? 2'b01 : 2'b00;
    localparam logic [1:0] ENC_DUART = (DUART_PORT == 8) ? 2'b10 : (DUART_PORT == 16) ? 2'b01 : 2'b00;
    localparam logic [1:0] ENC_EXP   = (EXP_PORT == 8)   ? 2'b10 : (EXP_PORT == 16)   ? 2'b01 : 2'b00;

    localparam logic [3:0] W_ROM   = 4'(ROM_WAIT);
    localparam logic [3:0] W_SRAM  = 4'(SRAM_WAIT);
    localparam logic [3:0] W_DUART = 4'(DUART_WAIT);
    localparam logic [2:0] IPL_LVL = 3'(DUART_IPL);
    localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);
    localparam logic [4:0] BOOT_LIM = 5'(BOOT_CYCLES);

    logic [1:0] state_q, state_d;
    logic [1:0] kind_q, kind_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic [1:0] enc_q, enc_d;
    logic       boot_q, boot_d;
    logic [3:0] boot_cnt_q, boot_cnt_d;
    logic       cs_rom_q, cs_rom_d, cs_sram_q, cs_sram_d;
    logic       cs_duart_q, cs_duart_d, cs_exp_q, cs_exp_d;
    logic       iack_q, iack_d, ciin_q, ciin_d;
    logic [1:0] dsack_q, dsack_d;
    logic       avec_q, avec_d, berr_q, berr_d;
    logic [2:0] ipl_q, ipl_d;

    logic       cpu_space, iack_cyc, release_all;
    logic [1:0] region;
    logic [8:0] tmo_inc;
    logic [4:0] boot_inc;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{AH[1:0], AL[0]};

    assign cpu_space = (FC == 3'b111);
    assign iack_cyc  = cpu_space && (AM == 4'hF);
    // The boot overlay maps every memory-space cycle onto the ROM
    assign region    = boot_q ? 2'b10 : AH[3:2];
    assign tmo_inc   = {1'b0, tmo_q} + 9'd1;
    assign boot_inc  = {1'b0, boot_cnt_q} + 5'd1;

    // Next-state logic for the cycle FSM, counters and output registers
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        wcnt_d      = wcnt_q;
        tmo_d       = tmo_q;
        enc_d       = enc_q;
        boot_d      = boot_q;
        boot_cnt_d  = boot_cnt_q;
        cs_rom_d    = cs_rom_q;
        cs_sram_d   = cs_sram_q;
        cs_duart_d  = cs_duart_q;
        cs_exp_d    = cs_exp_q;
        iack_d      = iack_q;
        ciin_d      = ciin_q;
        dsack_d     = dsack_q;
        avec_d      = avec_q;
        berr_d      = berr_q;
        ipl_d       = IRQ_DUART_n ? 3'b111 : ~IPL_LVL;
        release_all = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!AS_n) begin
                    state_d = S_WAIT;
                    tmo_d   = 8'd0;
                    kind_d  = K_FIXED;
                    if (iack_cyc) begin
                        if (AL[3:1] == IPL_LVL) begin
                            iack_d = 1'b0;
                            wcnt_d = W_DUART;
                            enc_d  = ENC_DUART;
                        end else begin
                            kind_d = K_AVEC;
                        end
                    end else if (cpu_space) begin
                        kind_d = K_BERR;
                    end else begin
                        unique case (region)
                            2'b00: begin cs_sram_d  = 1'b0; wcnt_d = W_SRAM;  enc_d = ENC_SRAM;  end
                            2'b01: begin cs_exp_d   = 1'b0; ciin_d = 1'b0; kind_d = K_EXP; enc_d = ENC_EXP; end
                            2'b10: begin cs_rom_d   = 1'b0; wcnt_d = W_ROM;   enc_d = ENC_ROM;   end
                            2'b11: begin cs_duart_d = 1'b0; ciin_d = 1'b0; wcnt_d = W_DUART; enc_d = ENC_DUART; end
                        endcase
                    end
                end
            end
            S_WAIT: begin
                if (AS_n) begin
                    // CPU gave up on the cycle: drop everything, no boot credit
                    state_d     = S_IDLE;
                    release_all = 1'b1;
                end else begin
                    case (kind_q)
                        K_AVEC: begin state_d = S_ACK;  avec_d = 1'b0; end
                        K_BERR: begin state_d = S_TERM; berr_d = 1'b0; end
                        default: begin
                            if ((kind_q == K_FIXED) ? (wcnt_q == 4'd0) : !EXP_RDY_n) begin
                                state_d = S_ACK;
                                dsack_d = enc_q;
                            end else begin
                                if (kind_q == K_FIXED) wcnt_d = wcnt_q - 4'd1;
                                tmo_d = tmo_inc[7:0];
                                if (tmo_inc == TMO_LIM) begin
                                    state_d = S_TERM;
                                    berr_d  = 1'b0;
                                end
                            end
                        end
                    endcase
                end
            end
            default: begin
                // ACK and TERM hold their outputs until the strobe goes away
                if (AS_n) begin
                    state_d     = S_IDLE;
                    release_all = 1'b1;
                    if (state_q == S_ACK && boot_q) begin
                        if (boot_cnt_q != 4'hF) boot_cnt_d = boot_inc[3:0];
                        boot_d = (boot_inc < BOOT_LIM);
                    end
                end
            end
        endcase

        if (release_all) begin
            cs_rom_d   = 1'b1;
            cs_sram_d  = 1'b1;
            cs_duart_d = 1'b1;
            cs_exp_d   = 1'b1;
            iack_d     = 1'b1;
            ciin_d     = 1'b1;
            dsack_d    = 2'b11;
            avec_d     = 1'b1;
            berr_d     = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            kind_q     <= K_FIXED;
            wcnt_q     <= 4'd0;
            tmo_q      <= 8'd0;
            enc_q      <= 2'b11;
            boot_q     <= 1'b1;
            boot_cnt_q <= 4'd0;
            cs_rom_q   <= 1'b1;
            cs_sram_q  <= 1'b1;
            cs_duart_q <= 1'b1;
            cs_exp_q   <= 1'b1;
            iack_q     <= 1'b1;
            ciin_q     <= 1'b1;
            dsack_q    <= 2'b11;
            avec_q     <= 1'b1;
            berr_q     <= 1'b1;
            ipl_q      <= 3'b111;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            wcnt_q     <= wcnt_d;
            tmo_q      <= tmo_d;
            enc_q      <= enc_d;
            boot_q     <= boot_d;
            boot_cnt_q <= boot_cnt_d;
            cs_rom_q   <= cs_rom_d;
            cs_sram_q  <= cs_sram_d;
            cs_duart_q <= cs_duart_d;
            cs_exp_q   <= cs_exp_d;
            iack_q     <= iack_d;
            ciin_q     <= ciin_d;
            dsack_q    <= dsack_d;
            avec_q     <= avec_d;
            berr_q     <= berr_d;
            ipl_q      <= ipl_d;
        end
    end

    assign DSACK1_n     = dsack_q[1];
    assign DSACK0_n     = dsack_q[0];
    assign BERR_n       = berr_q;
    assign AVEC_n       = avec_q;
    assign CIIN_n       = ciin_q;
    assign STERM_n      = 1'b1;
    assign IPL_n        = ipl_q;
    assign CS_ROM_n     = cs_rom_q;
    assign CS_SRAM_n    = cs_sram_q;
    assign CS_DUART_n   = cs_duart_q;
    assign CS_EXP_n     = cs_exp_q;
    assign IACK_DUART_n = iack_q;

endmodule

// File: tb/tb_system_bus_controller.sv
// tb/tb_system_bus_controller.sv - scoreboard bench for system_bus_controller
module tb_system_bus_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] AH, AM, AL;
    logic [2:0] FC;
    logic       AS_n, EXP_RDY_n, IRQ_DUART_n;
    logic       DSACK0_n, DSACK1_n, BERR_n, AVEC_n, CIIN_n, STERM_n;
    logic [2:0] IPL_n;
    logic       CS_ROM_n, CS_SRAM_n, CS_DUART_n, CS_EXP_n, IACK_DUART_n;

    system_bus_controller dut (
        .CLK(CLK), .RST(RST), .AH(AH), .AM(AM), .AL(AL), .FC(FC),
        .AS_n(AS_n), .EXP_RDY_n(EXP_RDY_n), .IRQ_DUART_n(IRQ_DUART_n),
        .DSACK0_n(DSACK0_n), .DSACK1_n(DSACK1_n), .BERR_n(BERR_n),
        .AVEC_n(AVEC_n), .CIIN_n(CIIN_n), .STERM_n(STERM_n), .IPL_n(IPL_n),
        .CS_ROM_n(CS_ROM_n), .CS_SRAM_n(CS_SRAM_n), .CS_DUART_n(CS_DUART_n),
        .CS_EXP_n(CS_EXP_n), .IACK_DUART_n(IACK_DUART_n)
    );

    always #5 CLK = ~CLK;

    // Output vector: ROM SRAM DUART EXP IACK CIIN D1 D0 AVEC BERR STERM IPL[2:0]
    localparam logic [13:0] ONES    = 14'h3FFF;
    localparam logic [13:0] M_ROM   = 14'h2000;
    localparam logic [13:0] M_SRAM  = 14'h1000;
    localparam logic [13:0] M_DUART = 14'h0800;
    localparam logic [13:0] M_EXP   = 14'h0400;
    localparam logic [13:0] M_IACK  = 14'h0200;
    localparam logic [13:0] M_CIIN  = 14'h0100;
    localparam logic [13:0] M_D1    = 14'h0080;
    localparam logic [13:0] M_D0    = 14'h0040;
    localparam logic [13:0] M_AVEC  = 14'h0020;
    localparam logic [13:0] M_BERR  = 14'h0010;
    localparam logic [13:0] M_IPL5  = 14'h0005;

    logic [13:0] outv;
    assign outv = {CS_ROM_n, CS_SRAM_n, CS_DUART_n, CS_EXP_n, IACK_DUART_n, CIIN_n,
                   DSACK1_n, DSACK0_n, AVEC_n, BERR_n, STERM_n, IPL_n};

    typedef struct {
        int          e;
        logic [13:0] v;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [13:0] prev;

    always @(posedge CLK) edge_n <= edge_n + 1;

    task automatic push(input int e, input logic [13:0] v, input string nm);
        exp_t x;
        x.e  = e;
        x.v  = v;
        x.nm = nm;
        sb.push_back(x);
    endtask

    // Monitor: every change of the output vector must match the next expected event
    always @(negedge CLK) begin
        if (mon_en && outv !== prev) begin
            prev = outv;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change edge %0d got %h required no change", edge_n, outv);
            end else begin
                cur = sb.pop_front();
                if (outv !== cur.v) begin
                    errors++;
                    $display("FAIL %s value got %h required %h (edge %0d)", cur.nm, outv, cur.v, edge_n);
                end
                checks++;
                if (edge_n != cur.e) begin
                    errors++;
                    $display("FAIL %s edge got %0d required %0d", cur.nm, edge_n, cur.e);
                end
            end
        end
    end

    task automatic begin_cycle(input logic [3:0] ah, input logic [3:0] am, input logic [3:0] al,
                               input logic [2:0] fc, output int k);
        @(posedge CLK); #1;
        AH = ah; AM = am; AL = al; FC = fc;
        AS_n = 1'b0;
        k = edge_n + 1;
    endtask

    // Release AS_n so that edge 'hi' is the first to sample it high
    task automatic end_cycle(input int hi);
        while (edge_n < hi - 1) begin @(posedge CLK); #1; end
        AS_n = 1'b1;
        while (edge_n < hi) begin @(posedge CLK); #1; end
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) begin @(posedge CLK); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at edge %0d required finish", edge_n);
        $fatal(1);
    end

    initial begin
        int k;
        RST = 1'b1; AH = 4'h0; AM = 4'h0; AL = 4'h0; FC = 3'b110;
        AS_n = 1'b1; EXP_RDY_n = 1'b1; IRQ_DUART_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1 AS_n = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (outv !== ONES) begin
            errors++;
            $display("FAIL reset_outputs got %h required %h", outv, ONES);
        end
        prev   = ONES;
        mon_en = 1'b1;
        @(posedge CLK); #1;
        AS_n = 1'b1; RST = 1'b0;

        // Two boot fetches from ROM, then SRAM at the same address
        for (int i = 0; i < 2; i++) begin
            begin_cycle(4'h0, 4'h0, 4'h0, 3'b110, k);
            push(k,     ONES & ~M_ROM,         "boot_rom_cs");
            push(k + 3, ONES & ~(M_ROM | M_D0), "boot_rom_dsack");
            push(k + 5, ONES,                  "boot_rom_end");
            end_cycle(k + 5);
        end
        begin_cycle(4'h0, 4'h0, 4'h0, 3'b110, k);
        push(k,     ONES & ~M_SRAM,                 "sram_cs");
        push(k + 1, ONES & ~(M_SRAM | M_D0 | M_D1), "sram_dsack");
        push(k + 3, ONES,                           "sram_end");
        end_cycle(k + 3);

        // DUART read at 0xC0000001
        begin_cycle(4'hC, 4'h0, 4'h1, 3'b101, k);
        push(k,     ONES & ~(M_DUART | M_CIIN),        "duart_cs");
        push(k + 4, ONES & ~(M_DUART | M_CIIN | M_D0), "duart_dsack");
        push(k + 5, ONES,                              "duart_end");
        end_cycle(k + 5);

        // Expansion access that never becomes ready
        begin_cycle(4'h4, 4'h0, 4'h0, 3'b101, k);
        push(k,      ONES & ~(M_EXP | M_CIIN),          "exp_cs");
        push(k + 64, ONES & ~(M_EXP | M_CIIN | M_BERR), "exp_timeout");
        push(k + 66, ONES,                              "exp_end");
        end_cycle(k + 66);

        // IACK at the DUART level
        begin_cycle(4'hF, 4'hF, 4'b1010, 3'b111, k);
        push(k,     ONES & ~M_IACK,         "iack_duart");
        push(k + 4, ONES & ~(M_IACK | M_D0), "iack_dsack");
        push(k + 6, ONES,                   "iack_end");
        end_cycle(k + 6);

        // IACK at level 2 -> autovector
        begin_cycle(4'hF, 4'hF, 4'b0100, 3'b111, k);
        push(k + 1, ONES & ~M_AVEC, "avec");
        push(k + 3, ONES,           "avec_end");
        end_cycle(k + 3);

        // CPU space, not IACK -> bus error
        begin_cycle(4'h0, 4'h2, 4'h0, 3'b111, k);
        push(k + 1, ONES & ~M_BERR, "cpu_berr");
        push(k + 3, ONES,           "cpu_berr_end");
        end_cycle(k + 3);

        // Aborted DUART cycle during wait states
        begin_cycle(4'hC, 4'h0, 4'h0, 3'b101, k);
        push(k,     ONES & ~(M_DUART | M_CIIN), "abort_cs");
        push(k + 2, ONES,                       "abort_end");
        end_cycle(k + 2);

        // Interrupt request to IPL
        @(posedge CLK); #1;
        IRQ_DUART_n = 1'b0;
        push(edge_n + 1, ONES & ~M_IPL5, "ipl_assert");
        wait_edge(edge_n + 3);
        IRQ_DUART_n = 1'b1;
        push(edge_n + 1, ONES, "ipl_release");
        wait_edge(edge_n + 2);

        // Reset during a ROM wait, then the overlay must be back
        begin_cycle(4'h8, 4'h0, 4'h0, 3'b110, k);
        push(k,     ONES & ~M_ROM, "rst_mid_cs");
        push(k + 1, ONES,          "rst_mid_clear");
        wait_edge(k);
        RST = 1'b1; AS_n = 1'b1;
        wait_edge(k + 3);
        RST = 1'b0;
        begin_cycle(4'h0, 4'h0, 4'h0, 3'b110, k);
        push(k,     ONES & ~M_ROM,          "reboot_rom_cs");
        push(k + 3, ONES & ~(M_ROM | M_D0), "reboot_rom_dsack");
        push(k + 5, ONES,                   "reboot_rom_end");
        end_cycle(k + 5);

        wait_edge(edge_n + 4);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never seen, required %h at edge %0d", cur.nm, cur.v, cur.e);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
